// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and the default
// frame constants used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

endpackage : uart_pkg

// File: rtl/uart_tx.sv
// UART transmitter: serialises DATA_BITS-wide words onto txd as start +
// data (LSB first) + optional parity + STOP_BITS stop bits. Each bit lasts
// OVERSAMPLE pulses of tx_en, the shared oversample tick from the baud
// generator. Defining UART_TX_PARITY_EN inserts a parity bit after the data
// bits, whose sense is selected by PARITY_ODD.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_en,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 txd
);

  localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

  uart_tx_state_t       state_q, state_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 done_q, done_d;
  logic                 txd_q, txd_d;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  logic bit_end;

  // State register and registered outputs; reset parks the line idle-high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      bit_q    <= '0;
      stop_q   <= 1'b0;
      shift_q  <= '0;
      done_q   <= 1'b0;
      txd_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
      shift_q  <= shift_d;
      done_q   <= done_d;
      txd_q    <= txd_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Next-state logic: tick divider, bit sequencing and the next txd level.
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    stop_d   = stop_q;
    shift_d  = shift_q;
    done_d   = 1'b0;
    txd_d    = txd_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    bit_end = tx_en && (tick_q == TICK_LAST);

    if (tx_en && (state_q != IDLE)) begin
      tick_d = bit_end ? '0 : tick_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          state_d  = START;
          shift_d  = tx_data;
          tick_d   = '0;
          bit_d    = '0;
          stop_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d = (^tx_data) ^ (PARITY_ODD != 0);
`endif
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_end) begin
          if (stop_q == STOP_LAST) begin
            state_d = IDLE;
            stop_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            stop_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      IDLE:    txd_d = 1'b1;
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_d = parity_q;
`else
      PARITY:  txd_d = 1'b1;
`endif
      STOP:    txd_d = 1'b1;
      default: txd_d = 1'b1;
    endcase
  end

  assign tx_ready = (state_q == IDLE);
  assign tx_busy  = (state_q != IDLE);
  assign tx_done  = done_q;
  assign txd      = txd_q;

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx. Expected frames are built from the data
// byte as a list of bit levels (start, data LSB first, optional parity,
// stop) and compared against txd bit by bit, along with handshake flags,
// tx_done timing and per-bit durations. Honours UART_TX_PARITY_EN.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int OS = UART_OVERSAMPLE;
  localparam int DB = UART_DATA_BITS;
  localparam int SB = 1;
  localparam int PO = 0;

  logic          clk = 1'b0;
  logic          rst;
  logic          tx_en;
  logic [DB-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          tx_busy;
  logic          tx_done;
  logic          txd;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int en_count    = 0;
  int done_count  = 0;
  int done_cyc    = 0;
  int en_period   = 1;
  int en_phase    = 0;

  logic exp_q[$];

  uart_tx #(
    .DATA_BITS (DB),
    .OVERSAMPLE(OS),
    .STOP_BITS (SB),
    .PARITY_ODD(PO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_en   (tx_en),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_busy (tx_busy),
    .tx_done (tx_done),
    .txd     (txd)
  );

  // 100 MHz system clock.
  always #5 clk = ~clk;

  // Oversample tick: one pulse every en_period clocks, changed on negedge.
  initial begin
    tx_en = 1'b0;
    forever begin
      @(negedge clk);
      if (en_phase + 1 >= en_period) en_phase = 0;
      else en_phase = en_phase + 1;
      tx_en = (en_phase == 0);
    end
  end

  // Free-running clock-edge and tick counters.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_en) en_count <= en_count + 1;
  end

  // Records every tx_done pulse and the edge it appeared on.
  always @(posedge clk) begin
    #1;
    if (tx_done === 1'b1) begin
      done_count <= done_count + 1;
      done_cyc   <= cyc;
    end
  end

  // Hang guard.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [DB-1:0] data, input logic valid);
    tx_data  = data;
    tx_valid = valid;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference frame: the list of line levels, one entry per bit period.
  function automatic void buildFrame(input logic [DB-1:0] data);
    int ones;
    ones = 0;
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < DB; i++) begin
      exp_q.push_back(data[i]);
      ones += int'(data[i]);
    end
`ifdef UART_TX_PARITY_EN
    exp_q.push_back(((ones % 2) == 1) ^ (PO != 0));
`endif
    for (int s = 0; s < SB; s++) exp_q.push_back(1'b1);
  endfunction

  // Offer a byte, wait for acceptance, then walk the frame bit by bit.
  task automatic sendFrame(input logic [DB-1:0] data, input bit keep_valid,
                           input logic [DB-1:0] next_data, input int inject_at,
                           input bit check_gap);
    int   n, base, accept_cyc, done_before, budget, target;
    logic level;
    bit   unstable, timeout, status_bad, len_bad;
    int   boundary[$];

    buildFrame(data);
    n = exp_q.size();
    applyStimulus(data, 1'b1);
    budget = 4000;
    while (!tx_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checkOutput("accept_wait", {31'd0, tx_ready}, 1);
    @(posedge clk);
    @(negedge clk);
    accept_cyc  = cyc;
    base        = en_count;
    done_before = done_count;
    if (check_gap) checkOutput("b2b_gap", accept_cyc - done_cyc, 1);
    checkOutput("accept_flags", {30'd0, tx_ready, tx_busy}, 2'b01);
    if (keep_valid) applyStimulus(next_data, 1'b1);
    else applyStimulus(DB'($urandom), 1'b0);

    status_bad = 1'b0;
    for (int b = 0; b < n; b++) begin
      target   = base + (b + 1) * OS;
      level    = txd;
      unstable = 1'b0;
      budget   = OS * en_period * 4 + 20;
      while (en_count < target && budget > 0) begin
        if (txd !== level) unstable = 1'b1;
        if (tx_ready !== 1'b0 || tx_busy !== 1'b1 || tx_done !== 1'b0) status_bad = 1'b1;
        if (inject_at > 0 && cyc - accept_cyc == inject_at) applyStimulus(8'h12, 1'b1);
        if (inject_at > 0 && cyc - accept_cyc == inject_at + 3) applyStimulus(DB'($urandom), 1'b0);
        @(negedge clk);
        budget--;
      end
      timeout = (en_count < target);
      boundary.push_back(cyc);
      checkOutput($sformatf("frame_%02h_bit%0d", data, b),
                  {29'd0, timeout, unstable, level}, {31'd0, exp_q[b]});
    end

    checkOutput("status_in_frame", {31'd0, status_bad}, 0);
    checkOutput("done_flags", {29'd0, tx_done, tx_ready, tx_busy}, 3'b110);
    checkOutput("done_count", done_count - done_before, 1);
    if (en_period == 1) checkOutput("frame_len", cyc - accept_cyc, n * OS);
    len_bad = 1'b0;
    for (int b = 1; b < n; b++) begin
      if (boundary[b] - boundary[b-1] != OS * en_period) len_bad = 1'b1;
    end
    checkOutput("bit_len", {31'd0, len_bad}, 0);
  endtask

  // Start a frame of 0x00, reset it during data bit 3, then check recovery.
  task automatic abortFrame();
    int base, budget, done_before;
    done_before = done_count;
    applyStimulus('0, 1'b1);
    budget = 4000;
    while (!tx_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    @(posedge clk);
    @(negedge clk);
    base = en_count;
    applyStimulus(8'h5A, 1'b0);
    budget = 4000;
    while (en_count < base + 4 * OS + 3 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checkOutput("pre_reset_txd", {30'd0, tx_busy, txd}, 2'b10);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_txd", {31'd0, txd}, 1);
    checkOutput("abort_flags", {29'd0, tx_ready, tx_busy, tx_done}, 3'b100);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("abort_no_done", done_count - done_before, 0);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus('0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("reset_txd", {31'd0, txd}, 1);
    checkOutput("reset_ready", {31'd0, tx_ready}, 1);
    checkOutput("reset_busy", {31'd0, tx_busy}, 0);
    checkOutput("reset_done", {31'd0, tx_done}, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    $display("[TB] reset released");

    en_period = 1;
    sendFrame(8'h55, 1'b0, '0, 0, 1'b0);

    repeat (3) @(negedge clk);
    sendFrame(8'hA3, 1'b1, 8'h0F, 0, 1'b0);
    sendFrame(8'h0F, 1'b0, '0, 0, 1'b1);

    repeat (3) @(negedge clk);
    en_period = 4;
    repeat (8) @(negedge clk);
    sendFrame(8'hFF, 1'b0, '0, 0, 1'b0);

    en_period = 1;
    repeat (8) @(negedge clk);
    sendFrame(8'h34, 1'b0, '0, 40, 1'b0);
    repeat (30) @(negedge clk);
    checkOutput("busy_ignore_idle", {30'd0, tx_busy, txd}, 2'b01);

    abortFrame();
    sendFrame(8'h81, 1'b0, '0, 0, 1'b0);

`ifdef UART_TX_PARITY_EN
    sendFrame(8'h07, 1'b0, '0, 0, 1'b0);
`endif

    for (int k = 0; k < 6; k++) begin
      en_period = 1 + int'($urandom_range(0, 2));
      repeat (6) @(negedge clk);
      sendFrame(DB'($urandom), 1'b0, '0, 0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_uart_tx
